// File: rtl/eth_tx_access_ctrl.sv
// eth_tx_access_ctrl: per-station CSMA/CD transmit access controller.
// Defers until the carrier has been quiet for the inter-frame gap, sends a frame,
// watches for late collisions, jams on collision and retries after a truncated
// binary exponential backoff whose slot count comes from an internal LFSR.
module eth_tx_access_ctrl #(
    parameter int         FRAME_LEN     = 4,
    parameter int         JAM_LEN       = 4,
    parameter int         IFG           = 2,
    parameter int         PROP          = 4,
    parameter int         MAX_ATTEMPTS  = 5,
    parameter int         BACKOFF_LIMIT = 4,
    parameter int         SLOT          = 1,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req,
    input  logic       i_cs,
    input  logic       i_cd,
    output logic [1:0] o_send,
    output logic [1:0] o_ack,
    output logic       o_busy,
    output logic [2:0] o_attempts
);

    // Symbol and status encodings shared with the rest of the Ethernet model
    localparam logic [1:0] SYM_JAM     = 2'd0;
    localparam logic [1:0] SYM_F       = 2'd1;
    localparam logic [1:0] SYM_ND      = 2'd2;
    localparam logic [1:0] ACK_FAIL    = 2'd0;
    localparam logic [1:0] ACK_SUCCESS = 2'd1;
    localparam logic [1:0] ACK_NA      = 2'd2;

    // An IFG of 0 still needs one quiet sample before transmitting
    localparam int         IFG_EFF = (IFG < 1) ? 1 : IFG;
    localparam logic [4:0] IFG_Q   = 5'(IFG_EFF);
    localparam logic [4:0] PROP_Q  = 5'(PROP);
    localparam logic [3:0] FL4     = 4'(FRAME_LEN);
    localparam logic [3:0] JL4     = 4'(JAM_LEN);
    localparam logic [3:0] BL4     = 4'(BACKOFF_LIMIT);
    localparam logic [2:0] MAX3    = 3'(MAX_ATTEMPTS);
    localparam logic [11:0] SLOT12 = 12'(SLOT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEFER,
        S_XMIT,
        S_PROP,
        S_JAM,
        S_BACKOFF
    } state_t;

    state_t      r_state;
    logic [7:0]  r_lfsr;
    logic [3:0]  r_qcnt;      // consecutive quiet cycles seen while deferring
    logic [3:0]  r_scnt;      // F or Jam symbols already issued in this burst
    logic [3:0]  r_pcnt;      // propagation-watch cycles already elapsed
    logic [11:0] r_bcnt;      // backoff cycles remaining
    logic [1:0]  r_send;
    logic [1:0]  r_ack;
    logic [2:0]  r_attempts;

    logic        w_lfsr_fb;
    logic [4:0]  w_qcnt_sum;
    logic [4:0]  w_pcnt_sum;
    logic [2:0]  w_n;
    logic [3:0]  w_k;
    logic [7:0]  w_mask;
    logic [7:0]  w_slots;
    logic [11:0] w_bcnt_load;

    // Small counters stop at all-ones instead of wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Feedback for taps 8,6,5,4 of the Fibonacci LFSR
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_qcnt_sum  = {1'b0, r_qcnt} + 5'd1;
    assign w_pcnt_sum  = {1'b0, r_pcnt} + 5'd1;

    // Backoff draw: attempt number n selects k = min(n, limit) low LFSR bits
    assign w_n         = r_attempts + 3'd1;
    assign w_k         = ({1'b0, w_n} > BL4) ? BL4 : {1'b0, w_n};
    assign w_mask      = 8'hFF >> (4'd8 - w_k);
    assign w_slots     = r_lfsr & w_mask;
    assign w_bcnt_load = {4'd0, w_slots} * SLOT12;

    assign o_send      = r_send;
    assign o_ack       = r_ack;
    assign o_attempts  = r_attempts;
    assign o_busy      = (r_state != S_IDLE);

    // Free-running LFSR, advances every cycle regardless of state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Access state machine with registered send/ack/attempts outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_qcnt     <= 4'd0;
            r_scnt     <= 4'd0;
            r_pcnt     <= 4'd0;
            r_bcnt     <= 12'd0;
            r_send     <= SYM_ND;
            r_ack      <= ACK_NA;
            r_attempts <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_send <= SYM_ND;
                    // The cycle after a completion only clears ack, so a
                    // request still held high cannot restart immediately
                    if (r_ack != ACK_NA) begin
                        r_ack <= ACK_NA;
                    end else if (i_req) begin
                        r_state <= S_DEFER;
                        r_qcnt  <= 4'd0;
                    end
                end

                S_DEFER: begin
                    if (i_cs) begin
                        r_qcnt <= 4'd0;
                    end else if (w_qcnt_sum >= IFG_Q) begin
                        r_state <= S_XMIT;
                        r_send  <= SYM_F;
                        r_scnt  <= 4'd1;
                        r_qcnt  <= 4'd0;
                    end else begin
                        r_qcnt <= sat_inc(r_qcnt);
                    end
                end

                S_XMIT: begin
                    if (i_cd) begin
                        r_state <= S_JAM;
                        r_send  <= SYM_JAM;
                        r_scnt  <= 4'd1;
                    end else if (r_scnt >= FL4) begin
                        r_state <= S_PROP;
                        r_send  <= SYM_ND;
                        r_pcnt  <= 4'd0;
                    end else begin
                        r_send <= SYM_F;
                        r_scnt <= sat_inc(r_scnt);
                    end
                end

                S_PROP: begin
                    if (i_cd) begin
                        r_state <= S_JAM;
                        r_send  <= SYM_JAM;
                        r_scnt  <= 4'd1;
                    end else if (w_pcnt_sum >= PROP_Q) begin
                        r_state    <= S_IDLE;
                        r_ack      <= ACK_SUCCESS;
                        r_attempts <= 3'd0;
                        r_pcnt     <= 4'd0;
                    end else begin
                        r_pcnt <= sat_inc(r_pcnt);
                    end
                end

                S_JAM: begin
                    if (r_scnt >= JL4) begin
                        r_send <= SYM_ND;
                        r_scnt <= 4'd0;
                        if (w_n == MAX3) begin
                            r_state    <= S_IDLE;
                            r_ack      <= ACK_FAIL;
                            r_attempts <= 3'd0;
                        end else begin
                            r_attempts <= w_n;
                            if (w_slots == 8'd0) begin
                                r_state <= S_DEFER;
                                r_qcnt  <= 4'd0;
                            end else begin
                                r_state <= S_BACKOFF;
                                r_bcnt  <= w_bcnt_load;
                            end
                        end
                    end else begin
                        r_send <= SYM_JAM;
                        r_scnt <= sat_inc(r_scnt);
                    end
                end

                S_BACKOFF: begin
                    if (r_bcnt <= 12'd1) begin
                        r_bcnt  <= 12'd0;
                        r_state <= S_DEFER;
                        r_qcnt  <= 4'd0;
                    end else begin
                        r_bcnt <= r_bcnt - 12'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_send  <= SYM_ND;
                    r_ack   <= ACK_NA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_access_ctrl.sv
// tb_eth_tx_access_ctrl: directed scenarios for the CSMA/CD access controller.
// A timeline model turns per-edge stimulus into per-edge expected outputs;
// one compare process checks the DUT after every edge, and literal checks pin
// the key timing points of each scenario.
module tb_eth_tx_access_ctrl;

    localparam int N             = 200;
    localparam int FRAME_LEN     = 4;
    localparam int JAM_LEN       = 4;
    localparam int IFG           = 2;
    localparam int PROP          = 4;
    localparam int MAX_ATTEMPTS  = 5;
    localparam int BACKOFF_LIMIT = 4;
    localparam int SLOT          = 1;
    localparam int IFG_EFF       = (IFG < 1) ? 1 : IFG;

    localparam logic [1:0] JAM   = 2'd0;
    localparam logic [1:0] F     = 2'd1;
    localparam logic [1:0] ND    = 2'd2;
    localparam logic [1:0] AFAIL = 2'd0;
    localparam logic [1:0] ASUCC = 2'd1;
    localparam logic [1:0] ANA   = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       cs;
    logic       cd;
    logic [1:0] send;
    logic [1:0] ack;
    logic       busy;
    logic [2:0] attempts;

    int tests = 0;
    int fails = 0;

    bit         req_v [N];
    bit         cs_v  [N];
    bit         cd_v  [N];
    logic [1:0] exp_send [N];
    logic [1:0] exp_ack  [N];
    logic       exp_busy [N];
    logic [2:0] exp_att  [N];
    logic [1:0] act_send [N];
    logic [1:0] act_ack  [N];
    logic       act_busy [N];
    logic [2:0] act_att  [N];

    bit chk_on = 1'b0;
    int cur_t  = 0;
    int cmp_idx;

    always #5 clk = ~clk;

    eth_tx_access_ctrl #(
        .FRAME_LEN(FRAME_LEN), .JAM_LEN(JAM_LEN), .IFG(IFG), .PROP(PROP),
        .MAX_ATTEMPTS(MAX_ATTEMPTS), .BACKOFF_LIMIT(BACKOFF_LIMIT),
        .SLOT(SLOT), .LFSR_SEED(8'hA5)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_cs(cs), .i_cd(cd),
        .o_send(send), .o_ack(ack), .o_busy(busy), .o_attempts(attempts)
    );

    function automatic void chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endfunction

    // LFSR value present just before post-reset edge k
    function automatic logic [7:0] lfsr_at(input int k);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic void mark(input int t, input logic [1:0] s, input logic [1:0] a,
                                 input logic b, input int at);
        if (t < N) begin
            exp_send[t] = s;
            exp_ack[t]  = a;
            exp_busy[t] = b;
            exp_att[t]  = 3'(at);
        end
    endfunction

    // Walk the stimulus timeline phase by phase and record what each edge must produce
    function automatic void build_model();
        int t, q, att, n, k, slots;
        bit done, coll;
        for (int i = 0; i < N; i++) mark(i, ND, ANA, 1'b0, 0);
        t = 0;
        while (t < N) begin
            if (!req_v[t]) begin
                mark(t, ND, ANA, 1'b0, 0);
                t++;
                continue;
            end
            mark(t, ND, ANA, 1'b1, 0);
            t++;
            att = 0;
            done = 1'b0;
            while (!done && t < N) begin
                q = 0;
                while (t < N) begin
                    if (cs_v[t]) q = 0; else q++;
                    if (!cs_v[t] && q >= IFG_EFF) break;
                    mark(t, ND, ANA, 1'b1, att);
                    t++;
                end
                if (t >= N) break;
                mark(t, F, ANA, 1'b1, att);
                t++;
                coll = 1'b0;
                for (int i = 1; i <= FRAME_LEN && t < N; i++) begin
                    if (cd_v[t]) begin coll = 1'b1; break; end
                    mark(t, (i == FRAME_LEN) ? ND : F, ANA, 1'b1, att);
                    t++;
                end
                if (!coll) begin
                    for (int p = 1; p <= PROP && t < N; p++) begin
                        if (cd_v[t]) begin coll = 1'b1; break; end
                        if (p == PROP) begin
                            mark(t, ND, ASUCC, 1'b0, 0);
                            t++;
                            mark(t, ND, ANA, 1'b0, 0);
                            t++;
                            done = 1'b1;
                        end else begin
                            mark(t, ND, ANA, 1'b1, att);
                            t++;
                        end
                    end
                end
                if (done || t >= N || !coll) break;
                for (int j = 0; j < JAM_LEN; j++) begin
                    mark(t, JAM, ANA, 1'b1, att);
                    t++;
                end
                if (t >= N) break;
                n = att + 1;
                if (n == MAX_ATTEMPTS) begin
                    mark(t, ND, AFAIL, 1'b0, 0);
                    t++;
                    mark(t, ND, ANA, 1'b0, 0);
                    t++;
                    done = 1'b1;
                end else begin
                    att = n;
                    k = (n < BACKOFF_LIMIT) ? n : BACKOFF_LIMIT;
                    slots = int'(lfsr_at(t)) % (1 << k);
                    mark(t, ND, ANA, 1'b1, att);
                    t++;
                    for (int b = 0; b < slots * SLOT; b++) begin
                        mark(t, ND, ANA, 1'b1, att);
                        t++;
                    end
                end
            end
        end
    endfunction

    // Per-edge comparison of every output against the model
    always @(posedge clk) begin
        if (chk_on) begin
            cmp_idx = cur_t;
            #1;
            act_send[cmp_idx] = send;
            act_ack[cmp_idx]  = ack;
            act_busy[cmp_idx] = busy;
            act_att[cmp_idx]  = attempts;
            chk($sformatf("send@E%0d", cmp_idx), int'(send), int'(exp_send[cmp_idx]));
            chk($sformatf("ack@E%0d", cmp_idx), int'(ack), int'(exp_ack[cmp_idx]));
            chk($sformatf("busy@E%0d", cmp_idx), int'(busy), int'(exp_busy[cmp_idx]));
            chk($sformatf("attempts@E%0d", cmp_idx), int'(attempts), int'(exp_att[cmp_idx]));
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            req_v[i] = 1'b0;
            cs_v[i]  = 1'b0;
            cd_v[i]  = 1'b0;
        end
    endtask

    task automatic start();
        chk_on = 1'b0;
        rst = 1'b1;
        req = 1'b0;
        cs  = 1'b0;
        cd  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_send", int'(send), int'(ND));
        chk("reset_ack", int'(ack), int'(ANA));
        chk("reset_busy", int'(busy), 0);
        chk("reset_attempts", int'(attempts), 0);
        rst = 1'b0;
        chk_on = 1'b1;
    endtask

    task automatic drive(input int upto);
        for (int t = 0; t < upto; t++) begin
            req = req_v[t];
            cs  = cs_v[t];
            cd  = cd_v[t];
            cur_t = t;
            @(negedge clk);
        end
        chk_on = 1'b0;
    endtask

    task automatic run(input string name);
        int f0;
        f0 = fails;
        build_model();
        start();
        drive(N);
        $display("[TB] scenario %s: %0d edges checked, %0d mismatches", name, N, fails - f0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tf, bursts;

        // Clean frame: req sampled only at E0
        clear_stim();
        req_v[0] = 1'b1;
        run("clean_frame");
        chk("clean_busy_E0", int'(act_busy[0]), 1);
        chk("clean_send_E1", int'(act_send[1]), int'(ND));
        chk("clean_send_E2", int'(act_send[2]), int'(F));
        chk("clean_send_E5", int'(act_send[5]), int'(F));
        chk("clean_send_E6", int'(act_send[6]), int'(ND));
        chk("clean_ack_E9", int'(act_ack[9]), int'(ANA));
        chk("clean_ack_E10", int'(act_ack[10]), int'(ASUCC));
        chk("clean_busy_E10", int'(act_busy[10]), 0);
        chk("clean_ack_E11", int'(act_ack[11]), int'(ANA));

        // Carrier defer: cs high through E5
        clear_stim();
        req_v[0] = 1'b1;
        for (int i = 1; i <= 5; i++) cs_v[i] = 1'b1;
        run("carrier_defer");
        chk("defer_send_E6", int'(act_send[6]), int'(ND));
        chk("defer_send_E7", int'(act_send[7]), int'(F));

        // Carrier pulse at E6 restarts the quiet count
        clear_stim();
        req_v[0] = 1'b1;
        for (int i = 1; i <= 4; i++) cs_v[i] = 1'b1;
        cs_v[6] = 1'b1;
        run("carrier_pulse");
        chk("pulse_send_E6", int'(act_send[6]), int'(ND));
        chk("pulse_send_E7", int'(act_send[7]), int'(ND));
        chk("pulse_send_E8", int'(act_send[8]), int'(F));

        // Collision during transmit; lfsr before E7 is 8'hA7 so one backoff slot
        clear_stim();
        req_v[0] = 1'b1;
        cd_v[3]  = 1'b1;
        run("xmit_collision");
        chk("coll_send_E3", int'(act_send[3]), int'(JAM));
        chk("coll_send_E6", int'(act_send[6]), int'(JAM));
        chk("coll_send_E7", int'(act_send[7]), int'(ND));
        chk("coll_att_E7", int'(act_att[7]), 1);
        chk("coll_send_E9", int'(act_send[9]), int'(ND));
        chk("coll_send_E10", int'(act_send[10]), int'(F));
        chk("coll_ack_E18", int'(act_ack[18]), int'(ASUCC));
        chk("coll_att_E18", int'(act_att[18]), 0);

        // Late collision at the third propagation edge
        clear_stim();
        req_v[0] = 1'b1;
        cd_v[9]  = 1'b1;
        run("late_collision");
        chk("late_send_E9", int'(act_send[9]), int'(JAM));
        chk("late_ack_E9", int'(act_ack[9]), int'(ANA));
        chk("late_att_E13", int'(act_att[13]), 1);

        // Exhaustion: every transmit collides, req held high throughout
        clear_stim();
        for (int i = 0; i < N; i++) begin
            req_v[i] = 1'b1;
            cd_v[i]  = 1'b1;
        end
        run("exhaustion");
        tf = -1;
        for (int i = 0; i < N; i++) begin
            if (tf < 0 && act_ack[i] == AFAIL) tf = i;
        end
        chk("exh_fail_found", int'(tf >= 0), 1);
        if (tf >= 0 && tf + 2 < N) begin
            bursts = 0;
            for (int i = 0; i < tf; i++) begin
                if (act_send[i] == JAM && (i == 0 || act_send[i-1] != JAM)) bursts++;
            end
            chk("exh_jam_bursts", bursts, 5);
            chk("exh_att_at_fail", int'(act_att[tf]), 0);
            chk("exh_busy_at_fail", int'(act_busy[tf]), 0);
            chk("exh_ack_after_fail", int'(act_ack[tf+1]), int'(ANA));
            chk("exh_busy_after_fail", int'(act_busy[tf+1]), 0);
            chk("exh_restart", int'(act_busy[tf+2]), 1);
        end

        // Reset asserted mid-jam takes effect without a clock edge
        clear_stim();
        req_v[0] = 1'b1;
        cd_v[3]  = 1'b1;
        build_model();
        start();
        drive(5);
        chk("midjam_send_E4", int'(act_send[4]), int'(JAM));
        #2;
        rst = 1'b1;
        #1;
        chk("midjam_rst_send", int'(send), int'(ND));
        chk("midjam_rst_ack", int'(ack), int'(ANA));
        chk("midjam_rst_busy", int'(busy), 0);
        chk("midjam_rst_attempts", int'(attempts), 0);
        $display("[TB] scenario reset_mid_jam: async reset checked");

        // Same collision after reset: identical backoff proves the LFSR reloaded
        run("collision_after_reset");
        chk("rerun_send_E10", int'(act_send[10]), int'(F));
        chk("rerun_ack_E18", int'(act_ack[18]), int'(ASUCC));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_tx_access_ctrl.md
Name: eth_tx_access_ctrl

Overview:
- Per-station medium-access controller for the Ethernet model (CSMA/CD with truncated binary exponential backoff).
- Sits between the LLC request/ack handshake and the PLS symbol line.
- Sequences defer, frame transmit, propagation watch, jam, backoff and retry. Draws backoff delays from an internal LFSR, so the block is fully synthesizable.
- Symbol and status encodings match the rest of the model: Jam=0, F=1, ND=2; Fail=0, Success=1, NA=2.

Parameters:
- FRAME_LEN, 4, F symbols per frame (1..15)
- JAM_LEN, 4, Jam symbols per collision (1..15)
- IFG, 2, consecutive quiet (cs=0) cycles required before transmitting (0..15)
- PROP, 4, cycles after the last F during which a cd still counts as a collision (1..15)
- MAX_ATTEMPTS, 5, collisions tolerated before Fail (1..7)
- BACKOFF_LIMIT, 4, maximum backoff exponent (1..8)
- SLOT, 1, cycles per backoff slot (1..15)
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  LLC transmit request (Req=1), level-sensitive
- cs  in  1  channel carrier sense
- cd  in  1  channel collision detect
- send  out  2  symbol to PLS (Jam/F/ND), registered
- ack  out  2  status to LLC (Fail/Success/NA), registered, 1-cycle pulse
- busy  out  1  high in every state except IDLE
- attempts  out  3  collisions counted for the current frame

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE, send=ND, ack=NA, busy=0, attempts=0, all counters 0, lfsr=LFSR_SEED.
  - No partial ack is produced.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in every state.
- ack returns to NA on the edge after it is driven to Success or Fail.
- IDLE:
  - On an edge with req=1 and ack==NA: go to DEFER, busy=1.
  - req is ignored on the edge where ack is non-NA, so a stale req cannot restart a frame.
- DEFER (send=ND):
  - qcnt increments on each edge with cs=0 and clears on cs=1.
  - On the edge where cs=0 and qcnt+1 >= max(IFG,1): go to XMIT and drive send=F.
- XMIT:
  - send=F for exactly FRAME_LEN edges.
  - cd sampled 1 on any XMIT edge: go to JAM (send=Jam) on that edge.
  - After the last F with no cd: go to PROP with send=ND.
- PROP (send=ND):
  - The PROP edges following entry each sample cd.
  - cd=1 on any of them: go to JAM.
  - On the PROP-th edge with cd=0: ack=Success, attempts=0, go to IDLE, busy=0.
- JAM:
  - send=Jam for exactly JAM_LEN edges; cd is ignored.
  - On exit, n=attempts+1.
  - If n == MAX_ATTEMPTS: ack=Fail, attempts=0, IDLE, send=ND.
  - Otherwise: attempts=n, k=min(n,BACKOFF_LIMIT), slots=lfsr[k-1:0] sampled on that edge.
  - slots=0: go straight to DEFER; else go to BACKOFF with bcnt=slots*SLOT.
- BACKOFF (send=ND):
  - bcnt decrements each edge; on reaching 0, go to DEFER.
  - cs and cd are ignored.
- Mid-operation req changes: req falling mid-frame is ignored. The frame runs to Success or Fail; req is only sampled in IDLE.
- Width rules:
  - bcnt is 12 bits, which holds the maximum 255*15.
  - qcnt, symbol and prop counters are 4 bits and saturate; they never wrap.
- At most one of Success/Fail per frame. ack is never non-NA while busy is 0, except on the completing edge.

Test Plan:
- Clean frame: req=1 sampled at E0, cs=cd=0, default parameters → send=F at E2..E5, ND from E6, ack=Success at E10 only, attempts=0, busy=0 after E10.
- Carrier defer: cs=1 until E5 then 0 → send stays ND until E7, first F at E7; cs pulse high at E6 restarts the IFG count.
- Collision in XMIT: cd=1 sampled at E3 → send=Jam at E3..E6, attempts=1; backoff of lfsr[0] slots, then a retry that succeeds with ack=Success; predicted LFSR value checked.
- Late collision: cd=1 at the third PROP edge → JAM entered, no Success; the retry path is taken.
- Exhaustion: cd forced high during every XMIT → exactly 5 jam bursts, ack=Fail once, attempts returns to 0, IDLE; req held high starts a new frame only after the ack edge.
- Reset mid-JAM: reset asserted asynchronously → send=ND, ack=NA, busy=0 immediately, before any clock; LFSR reloads 8'hA5.
